keccak_absorb_ctrl: RTL and testbench

- Sequential, handshaked absorb controller for the pipelined Keccak-f[1600] datapath.
- Holds the 1600-bit sponge state and XORs each incoming message block into the rate portion, using a rate selected per message by mode.
- Launches the permutation core through a start/done handshake and presents the final state to the squeeze stage through a valid/ready port.
- Counts absorbed blocks.

---
 rtl/keccak_pkg.sv | 21 ++
 rtl/keccak_rate_xor.sv | 20 ++
 rtl/keccak_absorb_ctrl.sv | 92 +++++++++
 tb/tb_keccak_absorb_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths, rate constants, mode encodings and absorb FSM states
package keccak_pkg;
  localparam int STATE_W = 1600;
  localparam int RATE_224 = 1152;
  localparam int RATE_256 = 1088;
  localparam int RATE_384 = 832;
  localparam int RATE_512 = 576;
  localparam logic [1:0] MODE_224 = 2'd0;
  localparam logic [1:0] MODE_256 = 2'd1;
  localparam logic [1:0] MODE_384 = 2'd2;
  localparam logic [1:0] MODE_512 = 2'd3;
  typedef logic [2:0] fsm_t;
  localparam fsm_t S_IDLE   = 3'd0;
  localparam fsm_t S_LAUNCH = 3'd1;
  localparam fsm_t S_WAIT   = 3'd2;
  localparam fsm_t S_ABSORB = 3'd3;
  localparam fsm_t S_OUT    = 3'd4;
  function automatic int rate_of(input logic [1:0] m);
    return m == MODE_224 ? RATE_224 : m == MODE_256 ? RATE_256 : m == MODE_384 ? RATE_384 : RATE_512;
  endfunction
endpackage

// File: rtl/keccak_rate_xor.sv
// keccak_rate_xor: XOR an MSB-aligned block into the rate lanes of a sponge state
//   state  in  1600      current sponge state
//   block  in  MAX_RATE  padded block, active bits block[MAX_RATE-1 -: rate]
//   mode   in  2         rate select
//   xored  out 1600      state with the rate lanes XORed, capacity untouched
module keccak_rate_xor import keccak_pkg::*; #(
  parameter int MAX_RATE = 1152
) (
  input  logic [STATE_W-1:0]  state,
  input  logic [MAX_RATE-1:0] block,
  input  logic [1:0]          mode,
  output logic [STATE_W-1:0]  xored
);
  logic [STATE_W-1:0] aligned;
  logic [STATE_W-1:0] mask;
  assign aligned = {block, {(STATE_W-MAX_RATE){1'b0}}};
  // top-rate bits set; bits of block below the active rate never reach the state
  assign mask = ~({STATE_W{1'b1}} >> rate_of(mode));
  assign xored = state ^ (aligned & mask);
endmodule

// File: rtl/keccak_absorb_ctrl.sv
// keccak_absorb_ctrl: handshaked sponge absorb controller driving a Keccak-f[1600] core
//   blk_valid/blk_ready/blk_data/blk_last/mode  message block input
//   perm_start/perm_state_in/perm_done/perm_state_out  permutation core handshake
//   digest_valid/digest_ready/state_out  final state to the squeeze stage
//   block_count  blocks absorbed in the current message (saturating)
//   mode_err     sticky, a message was started with a rate above MAX_RATE
module keccak_absorb_ctrl import keccak_pkg::*; #(
  parameter int MAX_RATE = 1152,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic [MAX_RATE-1:0] blk_data,
  input  logic                blk_last,
  output logic                perm_start,
  output logic [STATE_W-1:0]  perm_state_in,
  input  logic                perm_done,
  input  logic [STATE_W-1:0]  perm_state_out,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic [STATE_W-1:0]  state_out,
  output logic [CNT_W-1:0]    block_count,
  output logic                mode_err
);
  fsm_t fsm;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] xor_in;
  logic [STATE_W-1:0] xored;
  logic [1:0] mode_q;
  logic [1:0] xor_mode;
  logic last_q;
  logic in_idle;
  logic legal;
  assign in_idle = fsm == S_IDLE;
  assign legal = rate_of(mode) <= MAX_RATE;
  // the first block of a message uses the live mode, later blocks the latched one
  assign xor_in = in_idle ? '0 : state;
  assign xor_mode = in_idle ? mode : mode_q;
  keccak_rate_xor #(.MAX_RATE(MAX_RATE)) u_xor (
    .state(xor_in),
    .block(blk_data),
    .mode(xor_mode),
    .xored(xored)
  );
  assign blk_ready = in_idle || fsm == S_ABSORB;
  assign perm_start = fsm == S_LAUNCH;
  assign digest_valid = fsm == S_OUT;
  assign perm_state_in = state;
  assign state_out = state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      state <= '0;
      block_count <= '0;
      mode_q <= '0;
      last_q <= 1'b0;
      mode_err <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: if (blk_valid) begin
          if (legal) begin
            mode_q <= mode;
            state <= xored;
            block_count <= CNT_W'(1);
            last_q <= blk_last;
            fsm <= S_LAUNCH;
          end else mode_err <= 1'b1;
        end
        S_LAUNCH: fsm <= S_WAIT;
        S_WAIT: if (perm_done) begin
          state <= perm_state_out;
          fsm <= last_q ? S_OUT : S_ABSORB;
        end
        S_ABSORB: if (blk_valid) begin
          state <= xored;
          block_count <= block_count + CNT_W'(block_count != '1);
          last_q <= blk_last;
          fsm <= S_LAUNCH;
        end
        S_OUT: if (digest_ready) begin
          state <= '0;
          block_count <= '0;
          fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// tb_keccak_absorb_ctrl: directed scoreboard bench for keccak_absorb_ctrl
module tb_keccak_absorb_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mode = '0;
  logic blk_valid = 1'b0, blk_last = 1'b0, digest_ready = 1'b0;
  logic [1151:0] blk_data = '0;
  logic blk_ready, perm_start, perm_done, digest_valid, mode_err;
  logic [1599:0] perm_state_in, perm_state_out, state_out;
  logic [15:0] block_count;

  logic c_blk_ready, c_perm_start, c_digest_valid, c_mode_err;
  logic [1599:0] c_perm_state_in, c_state_out;
  logic [1:0] c_block_count;

  logic [1:0] b_mode = '0;
  logic b_blk_valid = 1'b0, b_blk_last = 1'b0, b_digest_ready = 1'b0;
  logic [1087:0] b_blk_data = '0;
  logic b_blk_ready, b_perm_start, b_perm_done, b_digest_valid, b_mode_err;
  logic [1599:0] b_perm_state_in, b_perm_state_out, b_state_out;
  logic [15:0] b_block_count;

  keccak_absorb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_last(blk_last), .perm_start(perm_start), .perm_state_in(perm_state_in),
    .perm_done(perm_done), .perm_state_out(perm_state_out), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .state_out(state_out), .block_count(block_count), .mode_err(mode_err)
  );

  // lock-step copy with a 2-bit counter to reach saturation quickly
  keccak_absorb_ctrl #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .mode(mode), .blk_valid(blk_valid), .blk_ready(c_blk_ready),
    .blk_data(blk_data), .blk_last(blk_last), .perm_start(c_perm_start), .perm_state_in(c_perm_state_in),
    .perm_done(perm_done), .perm_state_out(perm_state_out), .digest_valid(c_digest_valid),
    .digest_ready(digest_ready), .state_out(c_state_out), .block_count(c_block_count), .mode_err(c_mode_err)
  );

  keccak_absorb_ctrl #(.MAX_RATE(1088)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .blk_valid(b_blk_valid), .blk_ready(b_blk_ready),
    .blk_data(b_blk_data), .blk_last(b_blk_last), .perm_start(b_perm_start), .perm_state_in(b_perm_state_in),
    .perm_done(b_perm_done), .perm_state_out(b_perm_state_out), .digest_valid(b_digest_valid),
    .digest_ready(b_digest_ready), .state_out(b_state_out), .block_count(b_block_count), .mode_err(b_mode_err)
  );

  // permutation models: result is ready 3 cycles after the start pulse
  logic rot = 1'b0, pd = 1'b0, pd_force = 1'b0, bpd = 1'b0;
  logic [1599:0] pres = '0, bres = '0;
  int pcnt = 0, bcnt = 0, nstart = 0, bnstart = 0;
  assign perm_done = pd | pd_force;
  assign perm_state_out = pres;
  assign b_perm_done = bpd;
  assign b_perm_state_out = bres;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= 0;
      pd <= 1'b0;
    end else begin
      pd <= pcnt == 1;
      if (pcnt != 0) pcnt <= pcnt - 1;
      if (perm_start) begin
        pcnt <= 3;
        pres <= rot ? {perm_state_in[1598:0], perm_state_in[1599]} : perm_state_in;
        nstart <= nstart + 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= 0;
      bpd <= 1'b0;
    end else begin
      bpd <= bcnt == 1;
      if (bcnt != 0) bcnt <= bcnt - 1;
      if (b_perm_start) begin
        bcnt <= 3;
        bres <= b_perm_state_in;
        bnstart <= bnstart + 1;
      end
    end
  end

  int tests = 0, failed = 0;
  logic [1599:0] exp_a = '0;
  logic [1599:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1599:0] o, input logic [1599:0] e);
    int w = 0;
    tests++;
    for (int i = 0; i < 25; i++) if (o[i*64 +: 64] !== e[i*64 +: 64]) w = i;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s: word %0d observed %h expected %h", tag, w, o[w*64 +: 64], e[w*64 +: 64]);
    end
  endtask

  function automatic int rate(input logic [1:0] m);
    return m == 2'd0 ? 1152 : m == 2'd1 ? 1088 : m == 2'd2 ? 832 : 576;
  endfunction

  function automatic logic [1599:0] mx(input logic [1599:0] s, input logic [1599:0] p, input int r);
    for (int i = 0; i < 1600; i++) if (i >= 1600 - r) s[i] = s[i] ^ p[i];
    return s;
  endfunction

  function automatic logic [1151:0] rnd();
    logic [1151:0] v;
    for (int i = 0; i < 36; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send_a(input logic [1151:0] d, input logic l, input logic [1:0] m, input int r);
    int n = 0;
    blk_data = d;
    blk_last = l;
    mode = m;
    blk_valid = 1'b1;
    while (!blk_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("blk_ready_wait", 64'(n < 200), 1);
    @(negedge clk);
    blk_valid = 1'b0;
    exp_a = mx(exp_a, {d, 448'b0}, r);
    chk("perm_start_lat", perm_start, 1);
    chk_st("launch_state", perm_state_in, exp_a);
    if (rot) exp_a = {exp_a[1598:0], exp_a[1599]};
    if (l) exp_q.push_back(exp_a);
  endtask

  task automatic get_digest(input int bc, input int nblk, input int s0, input int hold);
    int n = 0;
    logic [1599:0] e = '0;
    logic [1599:0] snap;
    while (!digest_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("digest_wait", 64'(n < 200), 1);
    chk("scoreboard_nonempty", 64'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk_st("digest_state", state_out, e);
    chk_st("c_digest_state", c_state_out, e);
    chk("block_count", block_count, 64'(bc));
    chk("sat_block_count", c_block_count, 64'(bc > 3 ? 3 : bc));
    chk("start_pulses", 64'(nstart - s0), 64'(nblk));
    snap = state_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", digest_valid, 1);
      chk("hold_blk_ready", blk_ready, 0);
      chk_st("hold_state", state_out, snap);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    exp_a = '0;
  endtask

  initial begin
    logic [1151:0] d, d2;
    logic [1087:0] bd;
    int s0, bs, n;
    repeat (2) @(negedge clk);
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_perm_start", perm_start, 0);
    chk("rst_digest_valid", digest_valid, 0);
    chk("rst_block_count", block_count, 0);
    chk("rst_mode_err", mode_err, 0);
    chk_st("rst_state", state_out, '0);
    chk("rst_b_mode_err", b_mode_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single block, rate 1088, then backpressure with the next message waiting
    d = '0;
    d[1151:64] = '1;
    s0 = nstart;
    send_a(d, 1'b1, 2'd1, 1088);
    d2 = rnd();
    blk_data = d2;
    mode = 2'd3;
    blk_last = 1'b1;
    blk_valid = 1'b1;
    get_digest(1, 1, s0, 10);
    chk("next_msg_ready", blk_ready, 1);
    s0 = nstart;
    @(negedge clk);
    blk_valid = 1'b0;
    exp_a = mx('0, {d2, 448'b0}, 576);
    chk("next_msg_start", perm_start, 1);
    chk_st("next_msg_launch", perm_state_in, exp_a);
    exp_q.push_back(exp_a);
    get_digest(1, 1, s0, 0);

    // three blocks at rate 576 through a rotating permutation
    rot = 1'b1;
    s0 = nstart;
    send_a(rnd(), 1'b0, 2'd3, 576);
    send_a(rnd(), 1'b0, 2'd0, 576);
    send_a(rnd(), 1'b1, 2'd1, 576);
    get_digest(3, 3, s0, 0);

    // mode switched mid-message keeps the latched rate of 832
    s0 = nstart;
    send_a(rnd(), 1'b0, 2'd2, 832);
    d = '1;
    send_a(d, 1'b1, 2'd0, 832);
    get_digest(2, 2, s0, 0);
    rot = 1'b0;

    // five blocks: the 2-bit counter copy saturates at 3
    s0 = nstart;
    for (int i = 0; i < 5; i++) send_a(rnd(), 1'(i == 4), 2'd0, 1152);
    get_digest(5, 5, s0, 0);

    // MAX_RATE=1088 build: mode 0 is rejected, then a mode 1 message completes
    bs = bnstart;
    d = rnd();
    b_blk_data = d[1087:0];
    b_mode = 2'd0;
    b_blk_last = 1'b1;
    b_blk_valid = 1'b1;
    @(negedge clk);
    b_blk_valid = 1'b0;
    chk("b_mode_err", b_mode_err, 1);
    chk("b_ready_after_err", b_blk_ready, 1);
    chk("b_no_start", b_perm_start, 0);
    repeat (4) @(negedge clk);
    chk("b_no_start_count", 64'(bnstart - bs), 0);
    d = rnd();
    bd = d[1087:0];
    b_blk_data = bd;
    b_mode = 2'd1;
    b_blk_valid = 1'b1;
    @(negedge clk);
    b_blk_valid = 1'b0;
    chk("b_start", b_perm_start, 1);
    n = 0;
    while (!b_digest_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_digest_wait", 64'(n < 200), 1);
    chk_st("b_digest_state", b_state_out, mx('0, {bd, 512'b0}, 1088));
    chk("b_block_count", b_block_count, 1);
    chk("b_mode_err_sticky", b_mode_err, 1);
    b_digest_ready = 1'b1;
    @(negedge clk);
    b_digest_ready = 1'b0;
    chk("b_digest_cleared", b_digest_valid, 0);

    // reset while waiting for the permutation, then a stray done
    send_a(rnd(), 1'b0, 2'd1, 1088);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_blk_ready", blk_ready, 1);
    chk("mid_rst_perm_start", perm_start, 0);
    chk("mid_rst_digest_valid", digest_valid, 0);
    chk("mid_rst_block_count", block_count, 0);
    chk_st("mid_rst_state", perm_state_in, '0);
    exp_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pd_force = 1'b1;
    @(negedge clk);
    pd_force = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_digest_valid", digest_valid, 0);
      chk("post_rst_perm_start", perm_start, 0);
      chk("post_rst_blk_ready", blk_ready, 1);
      chk_st("post_rst_state", state_out, '0);
      @(negedge clk);
    end
    chk("a_mode_err", mode_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
